// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 serial-display responder.
// Holds the opcode bases of the TM1638 command set, the frame FSM state
// enum, the latched data-command mode, and a command-class decoder.
package tm1638_pkg;

  // Opcode bases as sent by an initiator (first byte of a frame).
  localparam logic [7:0] OP_DATA_WRITE = 8'h40;
  localparam logic [7:0] OP_DATA_READ  = 8'h42;
  localparam logic [7:0] OP_DATA_FIXED = 8'h44;
  localparam logic [7:0] OP_DISP_OFF   = 8'h80;
  localparam logic [7:0] OP_DISP_ON    = 8'h88;
  localparam logic [7:0] OP_ADDR_SET   = 8'hC0;

  // Single-bit field masks, derived from the difference between opcode bases.
  localparam logic [7:0] FIXED_MASK = OP_DATA_FIXED ^ OP_DATA_WRITE;
  localparam logic [7:0] ON_MASK    = OP_DISP_ON ^ OP_DISP_OFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE_DATA,
    S_READ_DATA,
    S_IGNORE
  } state_t;

  typedef enum logic {
    MODE_WRITE,
    MODE_READ
  } rw_mode_t;

  typedef struct packed {
    rw_mode_t rw;
    logic     fixed;
  } mode_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_DATA,
    CLS_DISP,
    CLS_ADDR
  } cmd_class_t;

  // Command class lives in bits [7:6] of the first byte of a frame.
  function automatic cmd_class_t cmd_class(input logic [7:0] b);
    case (b[7:6])
      OP_DATA_WRITE[7:6]: return CLS_DATA;
      OP_DISP_OFF[7:6]:   return CLS_DISP;
      OP_ADDR_SET[7:6]:   return CLS_ADDR;
      default:            return CLS_NONE;
    endcase
  endfunction

  // Only the 10 pattern in bits [1:0] selects key read; every other value writes.
  function automatic logic is_read_cmd(input logic [7:0] b);
    return b[1:0] == OP_DATA_READ[1:0];
  endfunction

endpackage

// File: rtl/tm1638_sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer for one asynchronous input,
// with single-clk rise and fall pulses taken from the synchronized level.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   d           - asynchronous input
//   rise, fall  - one-clk pulses on synchronized 0->1 / 1->0 transitions
// The chain resets to IDLE so that no edge is reported out of reset when
// the line sits at its idle level.
module sync_edge_detect #(
  parameter int   STAGES = 2,
  parameter logic IDLE   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic              level;

  assign level = chain[STAGES-1];

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value and statement order inside the block cannot matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{IDLE}};
      prev  <= IDLE;
    end else begin
      chain <= (chain << 1) | STAGES'(d);
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/tm1638_responder.sv
// tm1638_responder: target side of the TM1638 three-wire (STB/CLK/DIO) bus.
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   sck, cs, dio_i    - serial clock (idle high), chip select (active low), data pin in
//   dio_o, dio_e      - data pin out and its output enable (key-read bytes only)
//   key_in            - key-scan bytes reported on a key read
//   display_ram       - display RAM contents
//   display_on        - display-control on bit
//   brightness        - display-control pulse-width field
//   ram_wr, ram_addr  - one-clk strobe and address per display RAM byte written
// Bits arrive LSB first on sck rising edges; read data is launched on sck
// falling edges so the initiator can sample it on the following rising edge.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int RAM_COUNT   = 16,
  parameter int KEY_COUNT   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sck,
  input  logic                       cs,
  input  logic                       dio_i,
  output logic                       dio_o,
  output logic                       dio_e,
  input  logic [KEY_COUNT-1:0][7:0]  key_in,
  output logic [RAM_COUNT-1:0][7:0]  display_ram,
  output logic                       display_on,
  output logic [2:0]                 brightness,
  output logic                       ram_wr,
  output logic [3:0]                 ram_addr
);

  // A read frame returns the key bytes followed by zero padding up to this count.
  localparam int READ_BYTES = KEY_COUNT + 4;
  localparam int RB_W       = $clog2(READ_BYTES + 1);

  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] dio_sync;
  logic                   dio_s;

  state_t                 state, state_next;
  logic                   active;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift_reg;
  logic [7:0]             byte_val;
  logic                   byte_done;
  cmd_class_t             cls;
  logic                   take_cmd;
  mode_t                  mode;
  logic [3:0]             address;
  logic [KEY_COUNT-1:0][7:0] key_snap;
  logic [RB_W-1:0]        rd_byte;
  logic [2:0]             rd_bit;
  logic [7:0]             rd_data;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sck_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cs),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Data shares the sck synchronizer depth, so a sampled bit lines up with
  // the rising-edge pulse that qualifies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dio_sync <= '0;
    else       dio_sync <= (dio_sync << 1) | SYNC_STAGES'(dio_i);
  end
  assign dio_s = dio_sync[SYNC_STAGES-1];

  // State is S_IDLE whenever cs is high, so it also gates stray sck edges.
  assign active    = (state != S_IDLE);
  assign byte_val  = {dio_s, shift_reg};
  assign byte_done = active && sck_rise && (bit_cnt == 3'd7) && !cs_rise && !cs_fall;
  assign cls       = cmd_class(byte_val);
  assign take_cmd  = byte_done && (state == S_CMD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next takes its default before any branch, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = S_IDLE;
    end else if (cs_fall) begin
      state_next = S_CMD;
    end else if (take_cmd) begin
      case (cls)
        CLS_DATA: state_next = is_read_cmd(byte_val) ? S_READ_DATA : S_IGNORE;
        CLS_ADDR: state_next = S_WRITE_DATA;
        default:  state_next = S_IGNORE;
      endcase
    end
  end

  // NOTE: the key snapshot is always loaded by a read command before it is
  // used, so it is left out of the reset and stays plain storage.
  always_ff @(posedge clk) begin
    if (take_cmd && cls == CLS_DATA && is_read_cmd(byte_val)) key_snap <= key_in;
  end

  // Bytes past the snapshot read as zero.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (32'(rd_byte) == i) rd_data = key_snap[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      mode        <= '{rw: MODE_WRITE, fixed: 1'b0};
      address     <= '0;
      display_ram <= '0;
      display_on  <= 1'b0;
      brightness  <= '0;
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      dio_o       <= 1'b0;
      dio_e       <= 1'b0;
      rd_byte     <= '0;
      rd_bit      <= '0;
    end else begin
      ram_wr <= 1'b0;
      if (cs_rise || cs_fall) begin
        // Frame boundary: any partial byte and any read in progress are dropped.
        bit_cnt <= '0;
        dio_e   <= 1'b0;
        rd_byte <= '0;
        rd_bit  <= '0;
      end else begin
        if (active && sck_rise) begin
          bit_cnt   <= bit_cnt + 3'd1;
          shift_reg <= byte_val[7:1];
        end

        if (byte_done) begin
          case (state)
            S_CMD: begin
              case (cls)
                CLS_DATA: begin
                  mode.rw    <= is_read_cmd(byte_val) ? MODE_READ : MODE_WRITE;
                  mode.fixed <= |(byte_val & FIXED_MASK);
                end
                CLS_DISP: begin
                  display_on <= |(byte_val & ON_MASK);
                  brightness <= byte_val[2:0];
                end
                CLS_ADDR: address <= byte_val[3:0];
                default: ;
              endcase
            end
            S_WRITE_DATA: begin
              for (int i = 0; i < RAM_COUNT; i++) begin
                if (32'(address) == i) display_ram[i] <= byte_val;
              end
              ram_wr   <= (32'(address) < RAM_COUNT);
              ram_addr <= address;
              if (!mode.fixed) address <= address + 4'd1;
            end
            default: ;
          endcase
        end

        // Launch on falling edges; once the last byte is out, the next
        // falling edge releases the pin.
        if (state == S_READ_DATA && mode.rw == MODE_READ && sck_fall) begin
          if (32'(rd_byte) < READ_BYTES) begin
            dio_e  <= 1'b1;
            dio_o  <= rd_data[rd_bit];
            rd_bit <= rd_bit + 3'd1;
            if (rd_bit == 3'd7) rd_byte <= rd_byte + RB_W'(1);
          end else begin
            dio_e <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench for tm1638_responder. The main process acts as the
// bus initiator and, before each frame, a reference model derived from the
// command rules pushes the expected RAM writes and read bytes into queues.
// Two monitors pop and compare: one on ram_wr, one on the initiator's view
// of the data pin during key-read bytes.
module tb_tm1638_responder;
  import tm1638_pkg::*;

  localparam int RAM_COUNT = 16;
  localparam int KEY_COUNT = 4;
  localparam int HALF      = 80;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b1;
  logic cs = 1'b1;
  logic dio_drv = 1'b1;
  logic dio_pin;
  logic dio_o, dio_e;
  logic [KEY_COUNT-1:0][7:0] key_in;
  logic [RAM_COUNT-1:0][7:0] display_ram;
  logic display_on;
  logic [2:0] brightness;
  logic ram_wr;
  logic [3:0] ram_addr;

  always #5 clk = ~clk;

  // The pin as the initiator sees it.
  assign dio_pin = dio_e ? dio_o : dio_drv;

  tm1638_responder #(.RAM_COUNT(RAM_COUNT), .KEY_COUNT(KEY_COUNT), .SYNC_STAGES(2)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .sck         (sck),
    .cs          (cs),
    .dio_i       (dio_pin),
    .dio_o       (dio_o),
    .dio_e       (dio_e),
    .key_in      (key_in),
    .display_ram (display_ram),
    .display_on  (display_on),
    .brightness  (brightness),
    .ram_wr      (ram_wr),
    .ram_addr    (ram_addr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  fb[$];
  logic        in_read = 1'b0;

  logic [7:0]  m_ram[RAM_COUNT];
  logic        m_fixed, m_on;
  logic [2:0]  m_bright;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < RAM_COUNT; i++) m_ram[i] = 8'h00;
    m_fixed  = 1'b0;
    m_on     = 1'b0;
    m_bright = 3'd0;
  endtask

  // Reference behaviour for the frame held in fb.
  task automatic model_frame(input int n_read);
    logic [7:0] c;
    logic [3:0] a;
    if (fb.size() == 0) return;
    c = fb[0];
    case (c[7:6])
      2'b01: begin
        m_fixed = c[2];
        if (c[1:0] == 2'b10)
          for (int k = 0; k < n_read; k++) exp_rd.push_back(k < KEY_COUNT ? key_in[k] : 8'h00);
      end
      2'b10: begin
        m_on     = c[3];
        m_bright = c[2:0];
      end
      2'b11: begin
        a = c[3:0];
        for (int i = 1; i < fb.size(); i++) begin
          exp_wr.push_back({a, fb[i]});
          m_ram[a] = fb[i];
          if (!m_fixed) a = a + 4'd1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      dio_drv = b[i];
      #HALF;
      sck = 1'b1;
      #HALF;
    end
  endtask

  // One cs-low frame: bytes in fb, then n_read key-read bytes, then n_extra
  // bytes past the read window, then an optional partial byte.
  task automatic run_frame(input int n_read, input int n_extra, input int part, input logic new_keys);
    model_frame(n_read);
    @(negedge clk);
    cs = 1'b0;
    #100;
    foreach (fb[i]) send_bits(fb[i], 8);
    if (new_keys)
      for (int k = 0; k < KEY_COUNT; k++) key_in[k] = 8'($urandom);
    in_read = 1'b1;
    for (int k = 0; k < n_read; k++) send_bits(8'hFF, 8);
    in_read = 1'b0;
    for (int k = 0; k < n_extra; k++) send_bits(8'hFF, 8);
    if (part > 0) send_bits(8'($urandom), part);
    #100;
    cs = 1'b1;
    #200;
    check("dio_e_after_cs", 32'(dio_e), 32'd0);
  endtask

  task automatic check_model();
    check("display_on", 32'(display_on), 32'(m_on));
    check("brightness", 32'(brightness), 32'(m_bright));
    for (int i = 0; i < RAM_COUNT; i++) check($sformatf("ram[%0d]", i), 32'(display_ram[i]), 32'(m_ram[i]));
  endtask

  // Monitor: every ram_wr pulse must match the next expected write.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (ram_wr) begin
        check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(e[11:8]));
          check("wr_data", 32'(display_ram[ram_addr]), 32'(e[7:0]));
        end
      end
    end
  end

  // Monitor: initiator-side capture of read bytes and the enable window.
  initial begin
    logic [7:0] sh;
    int nb;
    sh = 8'h00;
    nb = 0;
    forever begin
      @(posedge sck or posedge cs);
      if (cs) begin
        nb = 0;
      end else if (in_read) begin
        check("dio_e_read", 32'(dio_e), 32'd1);
        sh = {dio_pin, sh[7:1]};
        nb++;
        if (nb == 8) begin
          nb = 0;
          check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
          if (exp_rd.size() != 0) check("rd_byte", 32'(sh), 32'(exp_rd.pop_front()));
        end
      end else begin
        check("dio_e_idle", 32'(dio_e), 32'd0);
      end
    end
  end

  initial begin
    logic [7:0] b;
    int kind, n_read, part;
    model_reset();
    for (int k = 0; k < KEY_COUNT; k++) key_in[k] = 8'h00;

    // Reset state while reset is held.
    #23;
    check("rst_dio_e", 32'(dio_e), 32'd0);
    check("rst_dio_o", 32'(dio_o), 32'd0);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_model();
    @(negedge clk);
    reset = 1'b0;
    #100;

    // Auto-increment fill of the whole RAM.
    fb = '{OP_DATA_WRITE};
    run_frame(0, 0, 0, 1'b0);
    fb.delete();
    fb.push_back(OP_ADDR_SET);
    for (int i = 0; i < 16; i++) fb.push_back(8'(i));
    run_frame(0, 0, 0, 1'b0);
    check_model();

    // Fixed address: both bytes land on address 5.
    fb = '{OP_DATA_FIXED};
    run_frame(0, 0, 0, 1'b0);
    fb = '{8'hC5, 8'hAA, 8'h55};
    run_frame(0, 0, 0, 1'b0);
    check_model();

    // Key read, with key_in changed after the command to exercise the snapshot.
    key_in[0] = 8'h01;
    key_in[1] = 8'h22;
    key_in[2] = 8'h40;
    key_in[3] = 8'h88;
    fb = '{OP_DATA_READ};
    run_frame(5, 0, 0, 1'b1);
    // Full read window, then one more byte during which the pin is released.
    fb = '{OP_DATA_READ};
    run_frame(KEY_COUNT + 4, 1, 0, 1'b1);

    // Display control.
    fb = '{8'h8F};
    run_frame(0, 0, 0, 1'b0);
    check_model();
    fb = '{OP_DISP_OFF};
    run_frame(0, 0, 0, 1'b0);
    check_model();

    // Address wrap 15 -> 0, then an aborted partial byte.
    fb = '{OP_DATA_WRITE};
    run_frame(0, 0, 0, 1'b0);
    fb = '{8'hCE, 8'h11, 8'h22, 8'h33};
    run_frame(0, 0, 4, 1'b0);
    check("idle_after_abort", 32'(u_dut.state), 32'(S_IDLE));
    check_model();

    // Randomized frames.
    for (int it = 0; it < 24; it++) begin
      fb.delete();
      n_read = 0;
      part = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: begin
          b = OP_DATA_WRITE | (($urandom_range(0, 1) == 1) ? FIXED_MASK : 8'h00);
          case ($urandom_range(0, 2))
            0:       b[1:0] = 2'b00;
            1:       b[1:0] = 2'b01;
            default: b[1:0] = 2'b11;
          endcase
          fb.push_back(b);
          if ($urandom_range(0, 1) == 1) fb.push_back(8'($urandom));
        end
        1: begin
          fb.push_back(OP_DISP_OFF | 8'($urandom_range(0, 15)));
          if ($urandom_range(0, 1) == 1) fb.push_back(8'($urandom));
        end
        2: begin
          fb.push_back(OP_ADDR_SET | 8'($urandom_range(0, 15)));
          for (int i = 0; i < int'($urandom_range(1, 5)); i++) fb.push_back(8'($urandom));
        end
        3: begin
          for (int k = 0; k < KEY_COUNT; k++) key_in[k] = 8'($urandom);
          fb.push_back(OP_DATA_READ | (($urandom_range(0, 1) == 1) ? FIXED_MASK : 8'h00));
          n_read = int'($urandom_range(1, 6));
          part = 0;
        end
        default: begin
          fb.push_back(8'($urandom_range(0, 63)));
          fb.push_back(8'($urandom));
        end
      endcase
      run_frame(n_read, 0, part, kind == 3);
      check_model();
    end

    // Reset in the middle of a key-read byte.
    fb = '{OP_DATA_READ};
    model_frame(0);
    @(negedge clk);
    cs = 1'b0;
    #100;
    send_bits(OP_DATA_READ, 8);
    in_read = 1'b1;
    send_bits(8'hFF, 3);
    sck = 1'b0;
    #HALF;
    reset = 1'b1;
    #1;
    check("rst_mid_dio_e", 32'(dio_e), 32'd0);
    in_read = 1'b0;
    model_reset();
    check_model();
    #(HALF - 1);
    sck = 1'b1;
    #HALF;
    cs = 1'b1;
    #100;
    @(negedge clk);
    reset = 1'b0;
    #100;
    fb = '{8'h8A};
    run_frame(0, 0, 0, 1'b0);
    check_model();
    // Mode is back to auto-increment after reset.
    fb = '{8'hC3, 8'h5A, 8'hA5};
    run_frame(0, 0, 0, 1'b0);
    check_model();

    #200;
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tm1638_responder.md
TM1638_RESPONDER -- requirements
Module: tm1638_responder

Interface
REQ-001 SHALL have parameter RAM_COUNT, default 16, display RAM bytes.
REQ-002 SHALL have parameter KEY_COUNT, default 4, key-scan bytes returned per read.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flops in each sck/cs/dio_i synchronizer.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sck  input  1  serial clock from initiator, idle high.
REQ-007 SHALL have port cs  input  1  chip select (STB), active low.
REQ-008 SHALL have port dio_i  input  1  data line as seen at the pin.
REQ-009 SHALL have port dio_o  output  1  data driven to the pin.
REQ-010 SHALL have port dio_e  output  1  pin output enable, high only during key-read bytes.
REQ-011 SHALL have port key_in  input  KEY_COUNT x 8  key-scan bytes to report.
REQ-012 SHALL have port display_ram  output  RAM_COUNT x 8  current display RAM contents.
REQ-013 SHALL have port display_on  output  1  display-control on bit.
REQ-014 SHALL have port brightness  output  3  display-control pulse-width field.
REQ-015 SHALL have port ram_wr  output  1  one-clk strobe per display RAM byte written.
REQ-016 SHALL have port ram_addr  output  4  address of the byte written, valid with ram_wr.

Function
REQ-017 SHALL synchronize sck, cs, dio_i through SYNC_STAGES flops; all edges are detected on synchronized signals.
REQ-018 SHALL sample dio_i on each sck rising edge while cs low; bits are LSB first; a byte completes on its 8th rising edge.
REQ-019 SHALL implement states S_IDLE, S_CMD, S_WRITE_DATA, S_READ_DATA, S_IGNORE.
REQ-020 SHALL enter S_CMD on cs falling edge and clear the bit counter.
REQ-021 SHALL return to S_IDLE on cs rising edge from any state, discard any partial byte, and deassert dio_e within 1 clk.
REQ-022 SHALL decode the first complete byte per frame: bits[7:6]=01 data command, 10 display control, 11 address set, 00 ignored.
REQ-023 Data command SHALL latch mode: bits[1:0]=00 write, 10 read keys (others treated as write); bit2=1 fixed address, 0 auto-increment; mode persists across frames.
REQ-024 Data command with read mode SHALL snapshot key_in and go to S_READ_DATA; otherwise go to S_IGNORE.
REQ-025 Display control SHALL update display_on=bit3, brightness=bits[2:0] on byte completion, then go to S_IGNORE.
REQ-026 Address set SHALL load address=bits[3:0] and go to S_WRITE_DATA.
REQ-027 In S_WRITE_DATA, each completed byte SHALL be written to display_ram[address], pulse ram_wr with ram_addr=address one clk after byte completion, then increment address mod 16 unless fixed mode.
REQ-028 Address wraps 15->0 in auto-increment mode; writes to address >= RAM_COUNT SHALL be dropped without ram_wr.
REQ-029 In S_READ_DATA, dio_e SHALL assert and dio_o SHALL present the next bit (LSB first) on each sck falling edge, starting with the falling edge after the command's 8th rising edge.
REQ-030 Read bytes SHALL be the snapshot bytes 0..KEY_COUNT-1 in order; bytes beyond KEY_COUNT SHALL read 0x00.
REQ-031 dio_e SHALL deassert on the falling edge after the 8th rising edge of the final byte KEY_COUNT+3 or on cs rise, whichever first.
REQ-032 S_IGNORE SHALL discard all further bytes until cs rises.
REQ-033 sck edges while cs high SHALL be ignored.

Reset
REQ-034 Reset SHALL clear display_ram to 0x00, display_on=0, brightness=0, dio_o=0, dio_e=0, ram_wr=0, ram_addr=0, mode write+auto-increment, address 0, state S_IDLE, synchronizers to idle (sck=1, cs=1).
REQ-035 Reset mid-frame SHALL abort the frame; the block SHALL wait for the next cs falling edge.

Structure
REQ-036 Package tm1638_pkg SHALL hold opcode constants (0x40, 0x42, 0x44, 0x80, 0x88, 0xC0 bases), the state enum, and mode typedef.
REQ-037 One sub-module sync_edge_detect (synchronizer plus rise/fall pulses) SHALL be instantiated per sck and cs; dio_i uses synchronizer only.

Verification
REQ-038 Frame 0x40; frame 0xC0 + 16 bytes 0x00..0x0F -> display_ram[i]=i, 16 ram_wr pulses, ram_addr 0..15.
REQ-039 Frame 0x44; frame 0xC5 + 0xAA,0x55 -> display_ram[5]=0x55, other bytes unchanged, two ram_wr at addr 5.
REQ-040 key_in={0x01,0x22,0x40,0x88}; frame 0x42 + 5 read bytes -> initiator captures 0x01,0x22,0x40,0x88,0x00; dio_e low outside read bytes.
REQ-041 Frame 0x8F -> display_on=1, brightness=7; frame 0x80 -> display_on=0, brightness=0.
REQ-042 Frame 0xCE + 0x11,0x22,0x33 -> addrs 14,15,0 written; then cs rise after 4 bits of a byte -> no write, state S_IDLE.
REQ-043 Assert reset during a read byte -> dio_e=0 immediately, display_ram all 0x00, next 0x8A frame sets brightness=2, display_on=1.
